// File: rtl/sync_fifo_stream_reader_pkg.sv
// Shared definitions for the sync_fifo read-side stream adapter.
package sync_fifo_stream_reader_pkg;

  // Default word width, kept identical to the sync_fifo default
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Reader state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  typedef enum logic [1:0] {
    RD_IDLE = ST_IDLE,
    RD_RUN  = ST_RUN,
    RD_STOP = ST_STOP
  } rd_state_e;

  // True when a new FIFO read still fits in the 2-entry output buffer,
  // counting the buffered words, the word already in flight, and the
  // word leaving the buffer on this edge.
  function automatic logic read_slot_free(
    input logic [1:0] buf_cnt,
    input logic       inflight,
    input logic       pop_now
  );
    logic [2:0] held;
    held = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop_now};
    return (held < 3'd2);
  endfunction

endpackage

// File: rtl/sync_fifo_stream_reader_skid_buf2.sv
// Two-entry valid/ready output buffer; the head entry drives the stream data.
module stream_skid_buf2
  import sync_fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_cnt
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_cnt;

  // Push/pop bookkeeping; the head keeps its last value when the buffer empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= {DATA_WIDTH{1'b0}};
      r_tail <= {DATA_WIDTH{1'b0}};
      r_cnt  <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          case (r_cnt)
            2'd0: begin
              r_head <= i_push_data;
              r_cnt  <= 2'd1;
            end
            2'd1: begin
              r_tail <= i_push_data;
              r_cnt  <= 2'd2;
            end
            default: begin
              // Full: the read-issue rule never pushes here
              r_cnt <= r_cnt;
            end
          endcase
        end
        2'b01: begin
          case (r_cnt)
            2'd1: begin
              r_cnt <= 2'd0;
            end
            2'd2: begin
              r_head <= r_tail;
              r_cnt  <= 2'd1;
            end
            default: begin
              // Pop of an empty buffer is gated off by o_valid
              r_cnt <= r_cnt;
            end
          endcase
        end
        2'b11: begin
          case (r_cnt)
            2'd0: begin
              // Cannot happen (no valid to pop); treat as plain push
              r_head <= i_push_data;
              r_cnt  <= 2'd1;
            end
            2'd1: begin
              r_head <= i_push_data;
            end
            2'd2: begin
              r_head <= r_tail;
              r_tail <= i_push_data;
            end
            default: begin
              r_cnt <= r_cnt;
            end
          endcase
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Read-side consumer for sync_fifo: pops words and re-issues them as a
// valid/ready stream, hiding the FIFO's one-cycle read latency.
module sync_fifo_stream_reader
  import sync_fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_out
);

  rd_state_e             r_state;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_words_out;

  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic [1:0]            w_buf_cnt;
  logic                  w_pop;
  logic                  w_rd;

  assign w_pop = w_valid & m_ready;

  // A read is issued only in RUN, never into an empty FIFO, and only if
  // its word is guaranteed a buffer slot when it lands next cycle.
  assign w_rd = (r_state == RD_RUN) && !fifo_empty &&
                read_slot_free(w_buf_cnt, r_inflight, w_pop);

  assign fifo_rd_en = w_rd;
  assign fifo_cs    = w_rd;

  stream_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_rdata),
    .i_pop       (w_pop),
    .o_valid     (w_valid),
    .o_data      (w_data),
    .o_cnt       (w_buf_cnt)
  );

  // Reader FSM plus the in-flight flag for the FIFO's registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RD_IDLE;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      case (r_state)
        RD_IDLE: begin
          if (enable) begin
            r_state <= RD_RUN;
          end else begin
            r_state <= RD_IDLE;
          end
        end
        RD_RUN: begin
          if (!enable) begin
            r_state <= RD_STOP;
          end else begin
            r_state <= RD_RUN;
          end
        end
        RD_STOP: begin
          if (enable) begin
            r_state <= RD_RUN;
          end else if (!r_inflight && (w_buf_cnt == 2'd0)) begin
            r_state <= RD_IDLE;
          end else begin
            r_state <= RD_STOP;
          end
        end
        default: begin
          r_state <= RD_IDLE;
        end
      endcase
    end
  end

  // Count accepted stream words; wraps naturally at the counter width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words_out <= {CNT_WIDTH{1'b0}};
    end else if (w_pop) begin
      r_words_out <= r_words_out + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_words_out <= r_words_out;
    end
  end

  assign m_valid   = w_valid;
  assign m_data    = w_data;
  assign words_out = r_words_out;
  assign busy      = (r_state == RD_RUN) || r_inflight || (w_buf_cnt != 2'd0);

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Self-checking bench for sync_fifo_stream_reader with a behavioural
// 8-deep sync_fifo model and a word-order/count reference model.
module tb_sync_fifo_stream_reader;

  localparam int DW     = 32;
  localparam int CW     = 16;
  localparam int DEPTH  = 8;
  localparam int LOG_SZ = 131072;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] words_out;

  // FIFO model: every word ever written is logged; wp/rp index the log
  logic [DW-1:0] wlog [0:LOG_SZ-1];
  int            wp;
  int            rp;
  // Reference model: next expected word index and expected accept count
  int            exp_idx;
  logic [CW-1:0] exp_words;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  int            n_chk;
  int            n_err;

  assign fifo_empty = (wp == rp);

  always #5 clk = ~clk;

  sync_fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .words_out  (words_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    if (wp < LOG_SZ) begin
      wlog[wp] = w;
      wp++;
    end
  endtask

  // One clock: monitor at negedge, FIFO pop at posedge, return at posedge+1
  task automatic tick();
    logic do_pop;
    @(negedge clk);
    do_pop = 1'b0;
    if (!rst_n) begin
      exp_idx    = rp;
      exp_words  = '0;
      prev_stall = 1'b0;
    end else begin
      check("words_out", words_out, exp_words);
      check("held_le_2", ((rp - exp_idx) <= 2), 1'b1);
      check("cs_eq_rd", fifo_cs, fifo_rd_en);
      if (fifo_rd_en === 1'b1) check("no_underflow", fifo_empty, 1'b0);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid === 1'b1 && m_ready) begin
        check("word_expected", (exp_idx < wp), 1'b1);
        if (exp_idx < wp) begin
          check("word_order", m_data, wlog[exp_idx]);
          exp_idx++;
          exp_words++;
        end
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
      do_pop     = (fifo_rd_en === 1'b1) && (wp != rp);
    end
    @(posedge clk);
    if (do_pop) begin
      fifo_rdata <= wlog[rp];
      rp         <= rp + 1;
    end
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    i = 0;
    do begin
      tick();
      i++;
    end while (busy !== 1'b0 && i < budget);
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_fifo_empty(input int budget, input string tag);
    int i;
    i = 0;
    while (wp != rp && i < budget) begin
      tick();
      i++;
    end
    check(tag, (wp == rp), 1'b1);
  endtask

  initial begin
    int  i;
    int  base;
    logic seen_ff;
    n_chk = 0; n_err = 0;
    wp = 0; rp = 0; exp_idx = 0; exp_words = '0;
    prev_stall = 1'b0; prev_data = '0;
    fifo_rdata = '0;
    enable = 1'b0; m_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_cs", fifo_cs, 1'b0);
    check("rst_rd", fifo_rd_en, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_words", words_out, 16'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Scenario 1: three words, latency and back-to-back delivery
    push(32'd1); push(32'd10); push(32'd100);
    m_ready = 1'b1; enable = 1'b1;
    tick(); check("s1_lat0", m_valid, 1'b0);
    tick(); check("s1_lat1", m_valid, 1'b0);
    tick(); check("s1_v0", m_valid, 1'b1); check("s1_d0", m_data, 32'd1);
    tick(); check("s1_v1", m_valid, 1'b1); check("s1_d1", m_data, 32'd10);
    tick(); check("s1_v2", m_valid, 1'b1); check("s1_d2", m_data, 32'd100);
    tick(); check("s1_count", words_out, 16'd3);
    enable = 1'b0;
    wait_idle(20, "s1_idle");

    // Scenario 2: full FIFO of powers of two, no bubbles after the first word
    for (int k = 0; k < 8; k++) push(32'd1 << k);
    enable = 1'b1;
    i = 0;
    while (m_valid !== 1'b1 && i < 10) begin tick(); i++; end
    for (int k = 0; k < 8; k++) begin
      check("s2_nobubble", m_valid, 1'b1);
      tick();
    end
    enable = 1'b0;
    wait_idle(20, "s2_idle");
    check("s2_count", words_out, 16'd11);
    check("s2_fifo_empty", fifo_empty, 1'b1);

    // Scenario 3: sink stalled for 10 cycles, exactly two pops
    for (int k = 0; k < 8; k++) push(k + 1);
    m_ready = 1'b0; enable = 1'b1; base = rp;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 3) begin
        check("s3_hold_valid", m_valid, 1'b1);
        check("s3_hold_data", m_data, 32'd1);
      end
    end
    check("s3_two_pops", rp - base, 2);
    check("s3_rd_off", fifo_rd_en, 1'b0);
    m_ready = 1'b1;
    wait_fifo_empty(40, "s3_fifo_drained");
    enable = 1'b0;
    wait_idle(20, "s3_idle");
    check("s3_count", words_out, 16'd19);

    // Scenario 4: sink ready toggling every cycle with random words
    for (int k = 0; k < 8; k++) push($urandom);
    enable = 1'b1; m_ready = 1'b1; i = 0;
    while (exp_idx != wp && i < 60) begin
      tick();
      m_ready = !m_ready;
      i++;
    end
    check("s4_all_delivered", exp_idx, wp);
    enable = 1'b0; m_ready = 1'b1;
    wait_idle(20, "s4_idle");
    check("s4_count", words_out, 16'd27);

    // Scenario 5: drop enable with one word in flight and one buffered
    for (int k = 0; k < 8; k++) push($urandom);
    m_ready = 1'b0; enable = 1'b1; base = rp;
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("s5_two_pops", rp - base, 2);
    check("s5_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    wait_idle(20, "s5_idle");
    check("s5_count", words_out, 16'd29);
    check("s5_fifo_keeps", wp - rp, 6);
    repeat (3) begin
      tick();
      check("s5_no_rd_idle", fifo_rd_en, 1'b0);
    end

    // Random traffic: random writes, sink readiness and enable drops
    for (int k = 0; k < 300; k++) begin
      enable  = ($urandom_range(0, 9) != 0);
      m_ready = $urandom_range(0, 1);
      if ((wp - rp) < DEPTH && $urandom_range(0, 1) == 1) push($urandom);
      tick();
    end
    enable = 1'b1; m_ready = 1'b1;
    wait_fifo_empty(60, "rnd_fifo_drained");
    enable = 1'b0;
    wait_idle(20, "rnd_idle");
    check("rnd_all_delivered", exp_idx, wp);

    // Scenario 6: asynchronous reset mid-stream, then counter wrap
    while ((wp - rp) < DEPTH) push($urandom);
    enable = 1'b1; m_ready = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("s6_rst_cs", fifo_cs, 1'b0);
    check("s6_rst_rd", fifo_rd_en, 1'b0);
    check("s6_rst_valid", m_valid, 1'b0);
    check("s6_rst_data", m_data, 32'd0);
    check("s6_rst_busy", busy, 1'b0);
    check("s6_rst_words", words_out, 16'd0);
    enable = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s6_no_rd_before_en", fifo_rd_en, 1'b0);
    end
    check("s6_fifo_nonempty", fifo_empty, 1'b0);
    enable = 1'b1; seen_ff = 1'b0; i = 0;
    while (i < 70000) begin
      if ((wp - rp) < DEPTH) push($urandom);
      tick();
      i++;
      if (exp_words == 16'hFFFF && !seen_ff) begin
        seen_ff = 1'b1;
        check("s6_words_ffff", words_out, 16'hFFFF);
      end
      if (seen_ff && exp_words == 16'h0000) begin
        check("s6_words_wrap", words_out, 16'h0000);
        break;
      end
    end
    check("s6_wrap_reached", (i < 70000), 1'b1);
    wait_fifo_empty(40, "s6_fifo_drained");
    enable = 1'b0;
    wait_idle(20, "s6_idle");
    check("s6_all_delivered", exp_idx, wp);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
